pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the write-enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sequences multi-cycle data-memory accesses from the EX/MEM stage through a req/ack handshake, detects load-use hazards, and squashes wrong-path instructions on a taken branch resolved in MEM. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.

---
 rtl/pipe_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: sequences multi-cycle data-memory
// accesses, resolves load-use hazards and squashes wrong-path work on taken branches.
module pipe_stall_ctrl #(
  parameter int LEN_INST_REG = 5,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_INST_REG-1:0] id_rs,
  input  logic [LEN_INST_REG-1:0] id_rt,
  input  logic                    id_uses_rt,
  input  logic                    idex_MemRead,
  input  logic [LEN_INST_REG-1:0] idex_rt,
  input  logic                    exmem_MemRead,
  input  logic                    exmem_MemWrite,
  input  logic                    exmem_PCSrc,
  input  logic                    mem_ack,
  output logic                    mem_req,
  output logic                    pc_we,
  output logic                    ifid_we,
  output logic                    idex_we,
  output logic                    exmem_we,
  output logic                    memwb_we,
  output logic                    flush_ifid,
  output logic                    flush_idex,
  output logic                    flush_exmem,
  output logic                    mem_err,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_acc;
  logic               load_use;
  logic               advance;

  assign mem_acc  = exmem_MemRead | exmem_MemWrite;
  assign load_use = idex_MemRead && (idex_rt != '0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    advance     = 1'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_acc) begin
          state_d = MEM_WAIT;
          tmo_d   = '0;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          advance = 1'b1;
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Abort a stuck access as if it completed, and remember that it happened.
          advance = 1'b1;
          state_d = RUN;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase

    if (advance) begin
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      memwb_we = 1'b1;
      if (exmem_PCSrc) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (load_use) begin
        flush_idex = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end

    if (!rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
    end

    req_d = (state_d == MEM_WAIT);
    cnt_d = cnt_q;
    if (!pc_we && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_err   = err_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (short timeout / narrow counter, and defaults)
// share stimulus and are compared every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, idex_MemRead, exmem_MemRead, exmem_MemWrite, exmem_PCSrc, mem_ack;

  logic a_req, a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_err;
  logic b_req, b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_err;
  logic [1:0]  a_cnt;
  logic [15:0] b_cnt;

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = instance A (timeout 4, 2-bit count), 1 = instance B (defaults)
  int   m_tmo[2]  = '{4, 64};
  int   m_cmax[2] = '{3, 65535};
  logic m_wait[2];
  int   m_cyc[2];
  logic m_err[2];
  int   m_cnt[2];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.LEN_INST_REG(5), .MEM_TIMEOUT(4), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .exmem_MemRead(exmem_MemRead),
    .exmem_MemWrite(exmem_MemWrite), .exmem_PCSrc(exmem_PCSrc), .mem_ack(mem_ack),
    .mem_req(a_req), .pc_we(a_pc), .ifid_we(a_ifid), .idex_we(a_idex), .exmem_we(a_exmem),
    .memwb_we(a_memwb), .flush_ifid(a_fifid), .flush_idex(a_fidex), .flush_exmem(a_fexmem),
    .mem_err(a_err), .stall_cnt(a_cnt));

  pipe_stall_ctrl u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .exmem_MemRead(exmem_MemRead),
    .exmem_MemWrite(exmem_MemWrite), .exmem_PCSrc(exmem_PCSrc), .mem_ack(mem_ack),
    .mem_req(b_req), .pc_we(b_pc), .ifid_we(b_ifid), .idex_we(b_idex), .exmem_we(b_exmem),
    .memwb_we(b_memwb), .flush_ifid(b_fifid), .flush_idex(b_fidex), .flush_exmem(b_fexmem),
    .mem_err(b_err), .stall_cnt(b_cnt));

  wire [9:0] a_vec = {a_req, a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_err};
  wire [9:0] b_vec = {b_req, b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_err};

  // Expected {req, pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_exmem, err}
  function automatic logic [9:0] model_out(int k);
    logic hazard, branch, adv;
    logic [4:0] we;
    logic [2:0] fl;
    hazard = idex_MemRead && (idex_rt != 0) &&
             ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    branch = exmem_PCSrc;
    if (!m_wait[k]) adv = !(exmem_MemRead || exmem_MemWrite);
    else            adv = mem_ack || (m_cyc[k] == m_tmo[k] - 1);
    we = 5'b00000;
    fl = 3'b000;
    if (rst && adv) begin
      if (branch)      begin we = 5'b11111; fl = 3'b111; end
      else if (hazard) begin we = 5'b00111; fl = 3'b010; end
      else             begin we = 5'b11111; end
    end
    return {m_wait[k], we, fl, m_err[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
    chk("A_outputs", {22'd0, a_vec}, {22'd0, model_out(0)});
    chk("B_outputs", {22'd0, b_vec}, {22'd0, model_out(1)});
    chk("A_stall_cnt", {30'd0, a_cnt}, m_cnt[0]);
    chk("B_stall_cnt", {16'd0, b_cnt}, m_cnt[1]);
  endtask

  task automatic tick();
    logic [9:0] e[2];
    logic acc;
    e[0] = model_out(0);
    e[1] = model_out(1);
    acc  = exmem_MemRead || exmem_MemWrite;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_wait[k] = 1'b0; m_cyc[k] = 0; m_err[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        if (!e[k][8] && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
        if (!m_wait[k]) begin
          if (acc) begin m_wait[k] = 1'b1; m_cyc[k] = 0; end
        end else if (mem_ack) begin
          m_wait[k] = 1'b0; m_cyc[k] = 0;
        end else if (m_cyc[k] == m_tmo[k] - 1) begin
          m_wait[k] = 1'b0; m_cyc[k] = 0; m_err[k] = 1'b1;
        end else begin
          m_cyc[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b1; id_rs = 5'd1; id_rt = 5'd2; idex_rt = 5'd3; id_uses_rt = 1'b0;
    idex_MemRead = 1'b0; exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
    exmem_PCSrc = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; settle(); tick(); rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    exmem_MemRead = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 1'b0; m_cyc[k] = 0; m_err[k] = 1'b0; m_cnt[k] = 0;
    end

    // Reset held with a pending load, then released
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_req", {31'd0, b_req}, 0);
      chk("rst_we", {27'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb}, 0);
      chk("rst_cnt", {16'd0, b_cnt}, 0);
      chk("rst_err", {31'd0, b_err}, 0);
      tick();
    end
    rst = 1'b1;
    settle();
    chk("rel_we", {27'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb}, 0);
    tick();
    settle();
    chk("rel_req", {31'd0, b_req}, 1);
    chk("wait1_pc", {31'd0, b_pc}, 0);
    tick();
    settle();
    chk("wait2_pc", {31'd0, b_pc}, 0);
    tick();
    mem_ack = 1'b1;
    settle();
    chk("ack_we", {27'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb}, 5'h1f);
    tick();
    mem_ack = 1'b0; exmem_MemRead = 1'b0;
    settle();
    chk("post_ack_req", {31'd0, b_req}, 0);
    chk("load_stall_cnt", {16'd0, b_cnt}, 3);
    tick();

    // Load-use variants
    idex_MemRead = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    settle();
    chk("lu_we", {27'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb}, 5'b00111);
    chk("lu_flush", {29'd0, b_fifid, b_fidex, b_fexmem}, 3'b010);
    tick();
    idex_rt = 5'd0; id_rs = 5'd0;
    settle();
    chk("lu_r0_pc", {31'd0, b_pc}, 1);
    tick();
    idex_rt = 5'd8; id_rs = 5'd1; id_rt = 5'd8; id_uses_rt = 1'b0;
    settle();
    chk("lu_rt_unused_pc", {31'd0, b_pc}, 1);
    tick();
    id_uses_rt = 1'b1;
    settle();
    chk("lu_rt_used_pc", {31'd0, b_pc}, 0);
    tick();

    // Branch takes priority over load-use
    exmem_PCSrc = 1'b1;
    settle();
    chk("br_flush", {29'd0, b_fifid, b_fidex, b_fexmem}, 3'b111);
    chk("br_we", {27'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb}, 5'h1f);
    tick();

    // Branch resolving on a store's ack cycle
    idle_inputs();
    exmem_MemWrite = 1'b1; exmem_PCSrc = 1'b1;
    settle();
    chk("st_detect_pc", {31'd0, b_pc}, 0);
    chk("st_detect_flush", {29'd0, b_fifid, b_fidex, b_fexmem}, 0);
    tick();
    mem_ack = 1'b1;
    settle();
    chk("st_ack_flush", {29'd0, b_fifid, b_fidex, b_fexmem}, 3'b111);
    chk("st_ack_pc", {31'd0, b_pc}, 1);
    tick();

    // Timeout on instance A; counter saturation at 3
    idle_inputs();
    do_reset();
    exmem_MemRead = 1'b1;
    settle(); tick();
    exmem_MemRead = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("tmo_wait_pc", {31'd0, a_pc}, 0);
      tick();
    end
    settle();
    chk("tmo_adv_pc", {31'd0, a_pc}, 1);
    tick();
    settle();
    chk("tmo_err", {31'd0, a_err}, 1);
    chk("tmo_req", {31'd0, a_req}, 0);
    chk("sat_cnt", {30'd0, a_cnt}, 3);
    tick();
    idex_MemRead = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
    settle(); tick();
    idle_inputs();
    for (int i = 0; i < 70; i++) begin
      mem_ack = (i == 3);
      exmem_MemWrite = (i == 5);
      settle(); tick();
    end
    settle();
    chk("err_sticky", {31'd0, a_err}, 1);
    chk("b_tmo_err", {31'd0, b_err}, 1);
    do_reset();
    settle();
    chk("err_cleared", {31'd0, a_err}, 0);
    tick();

    // Reset while waiting abandons the access without error
    exmem_MemRead = 1'b1;
    settle(); tick();
    exmem_MemRead = 1'b0;
    do_reset();
    settle();
    chk("rst_wait_req", {31'd0, b_req}, 0);
    chk("rst_wait_err", {31'd0, a_err}, 0);
    tick();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 59) != 0);
      exmem_MemRead  = ($urandom_range(0, 7) == 0);
      exmem_MemWrite = ($urandom_range(0, 9) == 0);
      exmem_PCSrc    = ($urandom_range(0, 5) == 0);
      mem_ack        = ($urandom_range(0, 3) == 0);
      idex_MemRead   = $urandom_range(0, 1) == 1;
      id_uses_rt     = $urandom_range(0, 1) == 1;
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      idex_rt        = 5'($urandom_range(0, 3));
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
